// File: rtl/intr_hub_pkg.sv
// Shared types and helpers for the interrupt hub.
package intr_hub_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } hub_state_e;

  // Ceiling log2, with a minimum result of 1 so that every field gets at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/intr_hub_if.sv
// Control and status bundle between the interrupt hub and its host.
interface intr_hub_if #(
  parameter int unsigned INT_NUM = 32,
  parameter int unsigned CNT_W   = 16
);
  import intr_hub_pkg::*;

  localparam int unsigned ID_W = clog2(INT_NUM);

  logic [INT_NUM-1:0] int_i;
  logic [INT_NUM-1:0] int_mode;
  logic [INT_NUM-1:0] int_pol;
  logic [INT_NUM-1:0] int_en;
  logic [INT_NUM-1:0] int_clr;
  logic               cnt_clr;
  logic               int_o;
  logic [ID_W-1:0]    int_id;
  logic               int_id_valid;
  logic [INT_NUM-1:0] int_pend;
  logic [CNT_W-1:0]   int_cnt;

  modport master (
    output int_i, int_mode, int_pol, int_en, int_clr, cnt_clr,
    input  int_o, int_id, int_id_valid, int_pend, int_cnt
  );

  modport slave (
    input  int_i, int_mode, int_pol, int_en, int_clr, cnt_clr,
    output int_o, int_id, int_id_valid, int_pend, int_cnt
  );

endinterface

// File: rtl/intr_hub_chan.sv
// One interrupt source: synchroniser, polarity, edge/level qualify and sticky pending bit.
module intr_hub_chan #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic int_i,
  input  logic int_mode,
  input  logic int_pol,
  input  logic int_clr,
  output logic pend
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s_c;
  logic                   set_c;

  // Normalised source level and its set condition; a set overrides a same-cycle clear.
  always_comb begin
    s_c   = sync_q[SYNC_STAGES-1] ^ int_pol;
    set_c = int_mode ? (s_c & ~prev_q) : s_c;
  end

  // Synchroniser chain, edge-detect history and pending bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pend   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], int_i};
      prev_q <= s_c;
      pend   <= set_c | (pend & ~int_clr);
    end
  end

endmodule

// File: rtl/intr_hub_ctrl.sv
// Interrupt aggregator: per-source channels, priority ID, assert/holdoff FSM, event counter.
module intr_hub_ctrl #(
  parameter int unsigned INT_NUM     = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  intr_hub_if.slave  bus
);
  import intr_hub_pkg::*;

  localparam int unsigned ID_W   = clog2(INT_NUM);
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? clog2(HOLDOFF) : 1;

  logic [INT_NUM-1:0] pend;
  logic [INT_NUM-1:0] active_c;
  logic               any_c;
  logic [ID_W-1:0]    id_c;
  logic               inc_c;

  hub_state_e         state_q;
  logic               int_o_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [ID_W-1:0]    int_id_q;
  logic               int_id_valid_q;
  logic [CNT_W-1:0]   int_cnt_q;

  for (genvar g = 0; g < INT_NUM; g++) begin : g_chan
    intr_hub_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .int_i    (bus.int_i[g]),
      .int_mode (bus.int_mode[g]),
      .int_pol  (bus.int_pol[g]),
      .int_clr  (bus.int_clr[g]),
      .pend     (pend[g])
    );
  end

  // Masked pending set, lowest-index priority encode and rising-edge event detect.
  always_comb begin
    active_c = pend & bus.int_en;
    any_c    = |active_c;
    id_c     = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (active_c[i]) id_c = ID_W'(i);
    end
    inc_c = any_c && ((state_q == IDLE) || ((state_q == HOLD) && (hold_q == '0)));
  end

  // Output FSM; a source still active when the holdoff expires re-asserts straight away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      int_o_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_c) begin
            state_q <= ASSERT;
            int_o_q <= 1'b1;
          end
        end
        ASSERT: begin
          if (!any_c) begin
            int_o_q <= 1'b0;
            if (HOLDOFF > 0) begin
              state_q <= HOLD;
              hold_q  <= HOLD_W'(HOLDOFF - 1);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            if (any_c) begin
              state_q <= ASSERT;
              int_o_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          int_o_q <= 1'b0;
        end
      endcase
    end
  end

  // Registered source ID; the ID holds its last value while nothing is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_id_q       <= '0;
      int_id_valid_q <= 1'b0;
    end else begin
      int_id_valid_q <= any_c;
      if (any_c) int_id_q <= id_c;
    end
  end

  // Saturating count of int_o rising edges; a coincident clear keeps the new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      int_cnt_q <= inc_c ? CNT_W'(1) : '0;
    end else if (inc_c && !(&int_cnt_q)) begin
      int_cnt_q <= int_cnt_q + CNT_W'(1);
    end
  end

  assign bus.int_o        = int_o_q;
  assign bus.int_id       = int_id_q;
  assign bus.int_id_valid = int_id_valid_q;
  assign bus.int_pend     = pend;
  assign bus.int_cnt      = int_cnt_q;

endmodule
